// File: rtl/coin_input_conditioner.sv
// Coin-slot front end: synchronises and debounces two raw sensor lines and emits one
// qualified coin code per physical coin, rejecting double-slot events.
module coin_input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       coin5_raw,
    input  logic       coin10_raw,
    input  logic       enable,
    output logic [1:0] coin_code,
    output logic       coin_valid,
    output logic       reject_pulse,
    output logic       busy,
    output logic [7:0] accept_count,
    output logic [7:0] reject_count
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        StIdle,
        StQualify,
        StEmit,
        StReject,
        StRelease
    } state_e;

    state_e                 r_state;
    logic [SYNC_STAGES-1:0] r_sync5;
    logic [SYNC_STAGES-1:0] r_sync10;
    logic [CNT_W-1:0]       r_cnt;
    logic [1:0]             r_sample;
    logic [7:0]             r_accept;
    logic [7:0]             r_reject;
    logic                   r_coin_valid;
    logic [1:0]             r_coin_code;
    logic                   r_reject_pulse;
    logic [1:0]             w_s;

    assign w_s = {r_sync10[SYNC_STAGES-1], r_sync5[SYNC_STAGES-1]};

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state        <= StIdle;
            r_sync5        <= '0;
            r_sync10       <= '0;
            r_cnt          <= '0;
            r_sample       <= 2'b00;
            r_accept       <= 8'd0;
            r_reject       <= 8'd0;
            r_coin_valid   <= 1'b0;
            r_coin_code    <= 2'b00;
            r_reject_pulse <= 1'b0;
        end else begin
            r_sync5        <= {r_sync5[SYNC_STAGES-2:0], coin5_raw};
            r_sync10       <= {r_sync10[SYNC_STAGES-2:0], coin10_raw};
            // Pulses last exactly the one cycle spent in EMIT/REJECT.
            r_coin_valid   <= 1'b0;
            r_coin_code    <= 2'b00;
            r_reject_pulse <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (enable && (w_s != 2'b00)) begin
                        r_sample <= w_s;
                        r_cnt    <= CNT_ONE;
                        r_state  <= StQualify;
                    end
                end
                StQualify: begin
                    if (!enable) begin
                        r_cnt   <= '0;
                        r_state <= StRelease;
                    end else if (w_s != r_sample) begin
                        r_cnt   <= '0;
                        r_state <= StIdle;
                    end else if (r_cnt == CNT_LAST) begin
                        if (r_sample == 2'b11) begin
                            r_reject_pulse <= 1'b1;
                            r_state        <= StReject;
                        end else begin
                            r_coin_valid <= 1'b1;
                            r_coin_code  <= r_sample;
                            r_state      <= StEmit;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                StEmit: begin
                    if (r_accept != 8'hFF) begin
                        r_accept <= r_accept + 8'd1;
                    end
                    r_cnt   <= '0;
                    r_state <= StRelease;
                end
                StReject: begin
                    if (r_reject != 8'hFF) begin
                        r_reject <= r_reject + 8'd1;
                    end
                    r_cnt   <= '0;
                    r_state <= StRelease;
                end
                StRelease: begin
                    // Both lines must read idle for DEBOUNCE_CYCLES in a row.
                    if (w_s == 2'b00) begin
                        if (r_cnt == CNT_LAST) begin
                            r_cnt   <= '0;
                            r_state <= StIdle;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end else begin
                        r_cnt <= '0;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign coin_valid   = r_coin_valid;
    assign coin_code    = r_coin_code;
    assign reject_pulse = r_reject_pulse;
    assign busy         = (r_state != StIdle);
    assign accept_count = r_accept;
    assign reject_count = r_reject;

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Randomised and directed bench for coin_input_conditioner against a timestamp-based
// behavioural model of the debounce/qualify/release rules.
module tb_coin_input_conditioner;

    localparam int S = 2;
    localparam int D = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       c5  = 1'b0;
    logic       c10 = 1'b0;
    logic       en  = 1'b0;
    logic [1:0] coin_code;
    logic       coin_valid;
    logic       reject_pulse;
    logic       busy;
    logic [7:0] accept_count;
    logic [7:0] reject_count;

    coin_input_conditioner #(
        .SYNC_STAGES    (S),
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (5)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .coin5_raw   (c5),
        .coin10_raw  (c10),
        .enable      (en),
        .coin_code   (coin_code),
        .coin_valid  (coin_valid),
        .reject_pulse(reject_pulse),
        .busy        (busy),
        .accept_count(accept_count),
        .reject_count(reject_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;

    // Model: phase 0 idle, 1 qualifying, 2 pulse(accept), 3 pulse(reject), 4 awaiting release.
    logic [1:0] m_delay[S];
    logic [1:0] m_v;
    logic [1:0] m_sample;
    int         m_phase, m_t0, m_zero, m_acc, m_rej;

    int n_valid = 0, n_reject = 0, last_valid_edge = 0, busy_fall_edge = 0;
    logic prev_busy = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_cnt, act, exp);
        end
    endtask

    always @(posedge clk) begin
        edge_cnt++;
        if (rst) begin
            for (int i = 0; i < S; i++) m_delay[i] = 2'b00;
            m_phase = 0; m_sample = 2'b00; m_t0 = 0; m_zero = 0; m_acc = 0; m_rej = 0;
        end else begin
            m_v = m_delay[S-1];
            for (int i = S - 1; i > 0; i--) m_delay[i] = m_delay[i-1];
            m_delay[0] = {c10, c5};
            case (m_phase)
                0: if (en && m_v != 2'b00) begin
                    m_sample = m_v; m_t0 = edge_cnt; m_phase = 1;
                end
                1: begin
                    if (!en) begin
                        m_phase = 4; m_zero = 0;
                    end else if (m_v != m_sample) begin
                        m_phase = 0;
                    end else if (edge_cnt - m_t0 == D - 1) begin
                        m_phase = (m_sample == 2'b11) ? 3 : 2;
                    end
                end
                2: begin
                    m_acc = (m_acc < 255) ? m_acc + 1 : 255; m_phase = 4; m_zero = 0;
                end
                3: begin
                    m_rej = (m_rej < 255) ? m_rej + 1 : 255; m_phase = 4; m_zero = 0;
                end
                default: begin
                    m_zero = (m_v == 2'b00) ? m_zero + 1 : 0;
                    if (m_zero == D) m_phase = 0;
                end
            endcase
        end
        #1;
        chk("coin_valid", int'(coin_valid), int'(m_phase == 2));
        chk("coin_code", int'(coin_code), (m_phase == 2) ? int'(m_sample) : 0);
        chk("reject_pulse", int'(reject_pulse), int'(m_phase == 3));
        chk("busy", int'(busy), int'(m_phase != 0));
        chk("accept_count", int'(accept_count), m_acc);
        chk("reject_count", int'(reject_count), m_rej);
        if (coin_valid) begin
            n_valid++;
            last_valid_edge = edge_cnt;
        end
        if (reject_pulse) n_reject++;
        if (prev_busy && !busy) busy_fall_edge = edge_cnt;
        prev_busy = busy;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    int start_e, v0, r0;

    initial begin
        cyc(3);
        rst = 1'b0;
        en  = 1'b1;
        cyc(2);
        chk("idle_after_reset", int'(busy), 0);

        // Clean 5-unit coin held 40 cycles.
        v0 = n_valid;
        start_e = edge_cnt + 1;
        c5 = 1'b1;
        cyc(40);
        start_e = edge_cnt + 1 - start_e;
        chk("t1_pulse_edge", last_valid_edge - (edge_cnt + 1 - start_e), 17);
        start_e = edge_cnt + 1;
        c5 = 1'b0;
        cyc(25);
        chk("t1_one_pulse", n_valid - v0, 1);
        chk("t1_accept", int'(accept_count), 1);
        chk("t1_busy_fall", busy_fall_edge - start_e, 17);

        // 10-unit coin with bounce: 1 1 0 1 0 1 then stable.
        v0 = n_valid;
        c10 = 1'b1; cyc(2);
        c10 = 1'b0; cyc(1);
        c10 = 1'b1; cyc(1);
        c10 = 1'b0; cyc(1);
        start_e = edge_cnt + 1;
        c10 = 1'b1; cyc(30);
        c10 = 1'b0; cyc(25);
        chk("t2_one_pulse", n_valid - v0, 1);
        chk("t2_pulse_edge", last_valid_edge - start_e, 17);
        chk("t2_accept", int'(accept_count), 2);

        // Short glitch.
        v0 = n_valid;
        c5 = 1'b1; cyc(5);
        c5 = 1'b0; cyc(20);
        chk("t3_no_pulse", n_valid - v0, 0);
        chk("t3_accept", int'(accept_count), 2);
        chk("t3_idle", int'(busy), 0);

        // Double-slot event.
        v0 = n_valid;
        r0 = n_reject;
        c5 = 1'b1; c10 = 1'b1; cyc(20);
        c5 = 1'b0; c10 = 1'b0; cyc(25);
        chk("t4_no_valid", n_valid - v0, 0);
        chk("t4_one_reject", n_reject - r0, 1);
        chk("t4_reject_count", int'(reject_count), 1);

        // Coin held while disabled, then enabled briefly before release.
        v0 = n_valid;
        en = 1'b0; c10 = 1'b1; cyc(30);
        en = 1'b1; cyc(8);
        c10 = 1'b0; cyc(25);
        chk("t5_no_pulse", n_valid - v0, 0);
        chk("t5_accept", int'(accept_count), 2);

        // Random segments checked cycle by cycle against the model.
        for (int seg = 0; seg < 150; seg++) begin
            c5  = ($urandom_range(0, 2) != 0);
            c10 = ($urandom_range(0, 3) == 0);
            en  = ($urandom_range(0, 5) != 0);
            cyc($urandom_range(1, 30));
            if ($urandom_range(0, 1) == 0) begin
                c5 = 1'b0; c10 = 1'b0;
                cyc($urandom_range(1, 25));
            end
        end
        c5 = 1'b0; c10 = 1'b0; en = 1'b1;
        cyc(40);

        // Saturation of the accept counter.
        for (int k = 0; k < 256; k++) begin
            if (k % 2 == 0) c5 = 1'b1;
            else c10 = 1'b1;
            cyc(20);
            c5 = 1'b0; c10 = 1'b0;
            cyc(19);
        end
        chk("t6_saturated", int'(accept_count), 255);

        // Reset during qualification of one more coin.
        v0 = n_valid;
        c5 = 1'b1; cyc(8);
        rst = 1'b1; c5 = 1'b0;
        @(posedge clk); #2;
        chk("t6_rst_valid", int'(coin_valid), 0);
        chk("t6_rst_code", int'(coin_code), 0);
        chk("t6_rst_reject", int'(reject_pulse), 0);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_acc", int'(accept_count), 0);
        chk("t6_rst_rej", int'(reject_count), 0);
        @(negedge clk);
        rst = 1'b0;
        cyc(30);
        chk("t6_no_pulse", n_valid - v0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/coin_input_conditioner.md
Name: coin_input_conditioner

Overview:
- Front-end stage feeding the vending-machine FSM's 2-bit coin input.
- Synchronises and debounces the two raw coin-slot sensor lines from the IO pads.
- Rejects glitches and double-slot events.
- Emits exactly one single-cycle coin code per physical coin, using the FSM encoding: 01 = 5, 10 = 10, 00 = none.
- Keeps saturating accept/reject counters for the management side.

Parameters:
SYNC_STAGES, 2, flip-flop stages in each raw-input synchroniser (min 2).
DEBOUNCE_CYCLES, 16, consecutive identical synchronised samples needed to qualify a press or a release (min 2).
CNT_W, 5, debounce counter width; must hold DEBOUNCE_CYCLES.

Ports:
wb_clk_i  input  1  single clock for the block.
wb_rst_i  input  1  synchronous, active-high reset.
coin5_raw  input  1  raw 5-unit slot sensor, asynchronous.
coin10_raw  input  1  raw 10-unit slot sensor, asynchronous.
enable  input  1  accept new coins when high.
coin_code  output  2  qualified coin code; 00 except during the coin_valid cycle.
coin_valid  output  1  one-cycle pulse with coin_code.
reject_pulse  output  1  one-cycle pulse on a qualified double-slot event.
busy  output  1  high whenever state != IDLE.
accept_count  output  8  accepted coins, saturates at 255.
reject_count  output  8  rejected events, saturates at 255.

Behaviour:
- Reset: interface and polarity
  - Interface: one clock (wb_clk_i); reset wb_rst_i is synchronous and active-high.
  - While wb_rst_i is high at a clock edge, the block clears all synchroniser flops, the counter, the latched sample, both totals and all outputs to 0, and sets the state to IDLE.
  - Reset mid-operation aborts any pending qualification; no pulse is emitted.
- Synchroniser: coin5_raw and coin10_raw each pass through SYNC_STAGES flops, giving s = {s10, s5}. All FSM logic uses s only.
- FSM states: IDLE, QUALIFY, EMIT, REJECT, RELEASE.
- IDLE:
  - enable=1 and s != 00: latch sample = s, set cnt = 1, go to QUALIFY.
  - Otherwise stay in IDLE.
- QUALIFY:
  - enable=0: go to RELEASE, so a coin inserted while disabled is never accepted.
  - s != sample: go to IDLE (glitch or code change). No output, no counter change.
  - s == sample and cnt == DEBOUNCE_CYCLES-1: go to EMIT if sample is 01 or 10; go to REJECT if sample is 11.
  - s == sample otherwise: cnt++.
- EMIT (one cycle):
  - coin_valid = 1, coin_code = sample.
  - accept_count++ (saturating).
  - Go to RELEASE.
- REJECT (one cycle):
  - reject_pulse = 1, coin_code = 00.
  - reject_count++ (saturating).
  - Go to RELEASE.
- RELEASE:
  - On entry, cnt = 0.
  - s == 00: cnt++. When cnt reaches DEBOUNCE_CYCLES, go to IDLE.
  - s != 00: cnt = 0.
  - A held coin therefore produces exactly one pulse.
- Outputs:
  - coin_valid, coin_code and reject_pulse are decoded from the registered state and sample only; they never depend combinationally on the raw inputs.
  - coin_valid and reject_pulse are never high together.
- Latency: clean step on one raw line, with the first capturing edge counted as edge 0.
  - s changes after edge SYNC_STAGES-1.
  - QUALIFY is entered at edge SYNC_STAGES.
  - EMIT is entered at edge SYNC_STAGES+DEBOUNCE_CYCLES-1, so coin_valid is high in the cycle after edge 17 for the defaults.
  - Minimum spacing between two accepted coins is 2*DEBOUNCE_CYCLES+1 cycles.
- enable toggling:
  - Has no effect in EMIT or REJECT (the pulse completes) or in RELEASE.
  - Gates only IDLE entry and QUALIFY continuation.
- Saturation: each counter holds at 255 and does not wrap.

Test Plan:
- Reset, then hold coin5_raw high for 40 cycles with enable=1 -> exactly one coin_valid with coin_code=01, high after edge 17; accept_count=1; busy returns to 0 16 cycles after s5 falls.
- 10-unit coin with 3 bounce toggles in the first 6 cycles, then stable high for 30 cycles -> single coin_code=10 pulse 16 cycles after the last bounce is synchronised; no extra pulses.
- Raw glitch of 5 cycles on coin5_raw -> no coin_valid, counts unchanged, FSM back in IDLE.
- coin5_raw and coin10_raw high together for 20 cycles -> reject_pulse once, coin_valid=0, reject_count=1.
- enable=0 while coin10_raw is held for 30 cycles, then enable=1 with the coin still held, then release -> no coin_valid at any point.
- 256 clean coins -> accept_count stays 255; assert wb_rst_i during QUALIFY of a further coin -> no pulse, all outputs 0 in the cycle after reset.
